// File: rtl/ctrl_pkg.sv
// Shared field positions, forwarding codes and opcodes for the control pipeline.
// decode() maps an opcode to its wb/m/ex control bundles.
package ctrl_pkg;

    localparam int WB_W = 2;
    localparam int M_W  = 3;
    localparam int EX_W = 4;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;
    localparam int M_BRANCH    = 2;
    localparam int M_MEMREAD   = 1;
    localparam int M_MEMWRITE  = 0;
    localparam int EX_REGDST   = 3;
    localparam int EX_ALUSRC   = 2;
    localparam int EX_ALUOP_HI = 1;
    localparam int EX_ALUOP_LO = 0;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;

    typedef struct packed {
        logic [WB_W-1:0] wb;
        logic [M_W-1:0]  m;
        logic [EX_W-1:0] ex;
    } ctrl_t;

    function automatic ctrl_t decode(input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                c.wb[WB_REGWRITE] = 1'b1;
                c.ex[EX_REGDST]   = 1'b1;
                c.ex[EX_ALUOP_HI] = 1'b1;
            end
            OP_LW: begin
                c.wb[WB_REGWRITE] = 1'b1;
                c.wb[WB_MEMTOREG] = 1'b1;
                c.m[M_MEMREAD]    = 1'b1;
                c.ex[EX_ALUSRC]   = 1'b1;
            end
            OP_SW: begin
                c.m[M_MEMWRITE]   = 1'b1;
                c.ex[EX_ALUSRC]   = 1'b1;
            end
            OP_BEQ: begin
                c.m[M_BRANCH]     = 1'b1;
                c.ex[EX_ALUOP_LO] = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// ALU operand forwarding selects for the instruction in EX; purely combinational.
// The younger producer in EX/MEM takes priority over MEM/WB; register $0 never forwards.
module fwd_unit
    import ctrl_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic            mem_regwrite,
    input  logic [RA_W-1:0] mem_dest,
    input  logic            wb_regwrite,
    input  logic [RA_W-1:0] wb_dest,
    input  logic [RA_W-1:0] ex_rs,
    input  logic [RA_W-1:0] ex_rt,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b
);

    logic mem_ok;
    logic wb_ok;

    assign mem_ok = mem_regwrite && (mem_dest != '0);
    assign wb_ok  = wb_regwrite && (wb_dest != '0);

    // NOTE: every output gets a default first so no path through the ifs infers a latch.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (mem_ok && (mem_dest == ex_rs))     fwd_a = FWD_MEM;
        else if (wb_ok && (wb_dest == ex_rs))  fwd_a = FWD_WB;
        if (mem_ok && (mem_dest == ex_rt))     fwd_b = FWD_MEM;
        else if (wb_ok && (wb_dest == ex_rt))  fwd_b = FWD_WB;
    end

endmodule

// File: rtl/ctrl_pipe_regs.sv
// ID/EX, EX/MEM and MEM/WB control staging with load-use stall, MEM-resolved branch
// flush, EX forwarding selects and a retired-instruction counter.
module ctrl_pipe_regs
    import ctrl_pkg::*;
#(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WB_W-1:0]  id_wb,
    input  logic [M_W-1:0]   id_m,
    input  logic [EX_W-1:0]  id_ex,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             ex_zero,
    output logic [EX_W-1:0]  ex_ex,
    output logic [M_W-1:0]   ex_m,
    output logic [WB_W-1:0]  ex_wb,
    output logic [M_W-1:0]   mem_m,
    output logic [WB_W-1:0]  mem_wb,
    output logic [WB_W-1:0]  wb_wb,
    output logic [RA_W-1:0]  ex_dest,
    output logic [RA_W-1:0]  mem_dest,
    output logic [RA_W-1:0]  wb_dest,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall,
    output logic             flush_ifid,
    output logic             branch_taken,
    output logic [CNT_W-1:0] retired
);

    logic [EX_W-1:0]  ex_ex_q, ex_ex_d;
    logic [M_W-1:0]   ex_m_q, ex_m_d;
    logic [WB_W-1:0]  ex_wb_q, ex_wb_d;
    logic             ex_valid_q, ex_valid_d;
    logic [RA_W-1:0]  ex_dest_q, ex_dest_d;
    logic [RA_W-1:0]  ex_rs_q, ex_rs_d;
    logic [RA_W-1:0]  ex_rt_q, ex_rt_d;

    logic [M_W-1:0]   mem_m_q, mem_m_d;
    logic [WB_W-1:0]  mem_wb_q, mem_wb_d;
    logic             mem_valid_q, mem_valid_d;
    logic             mem_zero_q, mem_zero_d;
    logic [RA_W-1:0]  mem_dest_q, mem_dest_d;

    logic [WB_W-1:0]  wb_wb_q, wb_wb_d;
    logic             wb_valid_q, wb_valid_d;
    logic [RA_W-1:0]  wb_dest_q, wb_dest_d;

    logic [CNT_W-1:0] retired_q, retired_d;

    // Flush outranks stall: a load being squashed cannot hold the front end.
    assign branch_taken = mem_m_q[M_BRANCH] & mem_zero_q;
    assign flush_ifid   = branch_taken;
    assign stall        = ex_m_q[M_MEMREAD] & id_valid & (ex_dest_q != '0)
                        & ((ex_dest_q == id_rs) | (ex_dest_q == id_rt)) & ~branch_taken;

    always_comb begin
        ex_dest_d  = id_ex[EX_REGDST] ? id_rd : id_rt;
        ex_rs_d    = id_rs;
        ex_rt_d    = id_rt;
        ex_ex_d    = '0;
        ex_m_d     = '0;
        ex_wb_d    = '0;
        ex_valid_d = 1'b0;
        if (id_valid && !stall && !branch_taken) begin
            ex_ex_d    = id_ex;
            ex_m_d     = id_m;
            ex_wb_d    = id_wb;
            ex_valid_d = 1'b1;
        end
    end

    always_comb begin
        mem_dest_d  = ex_dest_q;
        mem_m_d     = '0;
        mem_wb_d    = '0;
        mem_valid_d = 1'b0;
        mem_zero_d  = 1'b0;
        if (!branch_taken) begin
            mem_m_d     = ex_m_q;
            mem_wb_d    = ex_wb_q;
            mem_valid_d = ex_valid_q;
            mem_zero_d  = ex_zero;
        end
    end

    always_comb begin
        wb_wb_d    = mem_wb_q;
        wb_dest_d  = mem_dest_q;
        wb_valid_d = mem_valid_q;
        retired_d  = retired_q + {{(CNT_W-1){1'b0}}, wb_valid_q};
    end

    // NOTE: state updates use non-blocking assignments so every stage samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ex_q     <= '0;
            ex_m_q      <= '0;
            ex_wb_q     <= '0;
            ex_valid_q  <= 1'b0;
            ex_dest_q   <= '0;
            ex_rs_q     <= '0;
            ex_rt_q     <= '0;
            mem_m_q     <= '0;
            mem_wb_q    <= '0;
            mem_valid_q <= 1'b0;
            mem_zero_q  <= 1'b0;
            mem_dest_q  <= '0;
            wb_wb_q     <= '0;
            wb_valid_q  <= 1'b0;
            wb_dest_q   <= '0;
            retired_q   <= '0;
        end else begin
            ex_ex_q     <= ex_ex_d;
            ex_m_q      <= ex_m_d;
            ex_wb_q     <= ex_wb_d;
            ex_valid_q  <= ex_valid_d;
            ex_dest_q   <= ex_dest_d;
            ex_rs_q     <= ex_rs_d;
            ex_rt_q     <= ex_rt_d;
            mem_m_q     <= mem_m_d;
            mem_wb_q    <= mem_wb_d;
            mem_valid_q <= mem_valid_d;
            mem_zero_q  <= mem_zero_d;
            mem_dest_q  <= mem_dest_d;
            wb_wb_q     <= wb_wb_d;
            wb_valid_q  <= wb_valid_d;
            wb_dest_q   <= wb_dest_d;
            retired_q   <= retired_d;
        end
    end

    fwd_unit #(.RA_W(RA_W)) u_fwd (
        .mem_regwrite (mem_wb_q[WB_REGWRITE]),
        .mem_dest     (mem_dest_q),
        .wb_regwrite  (wb_wb_q[WB_REGWRITE]),
        .wb_dest      (wb_dest_q),
        .ex_rs        (ex_rs_q),
        .ex_rt        (ex_rt_q),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b)
    );

    assign ex_ex    = ex_ex_q;
    assign ex_m     = ex_m_q;
    assign ex_wb    = ex_wb_q;
    assign mem_m    = mem_m_q;
    assign mem_wb   = mem_wb_q;
    assign wb_wb    = wb_wb_q;
    assign ex_dest  = ex_dest_q;
    assign mem_dest = mem_dest_q;
    assign wb_dest  = wb_dest_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_ctrl_pipe_regs.sv
// Directed-vector bench for ctrl_pipe_regs: pipeline latency, load-use stall,
// forwarding priority, branch flush and asynchronous reset.
module tb_ctrl_pipe_regs;
    import ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [1:0]  id_wb;
    logic [2:0]  id_m;
    logic [3:0]  id_ex;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        ex_zero;
    logic [3:0]  ex_ex;
    logic [2:0]  ex_m, mem_m;
    logic [1:0]  ex_wb, mem_wb, wb_wb;
    logic [4:0]  ex_dest, mem_dest, wb_dest;
    logic [1:0]  fwd_a, fwd_b;
    logic        stall, flush_ifid, branch_taken;
    logic [31:0] retired;

    int vectors = 0;
    int miscompares = 0;

    ctrl_pipe_regs dut (
        .clk(clk), .rst_n(rst_n),
        .id_wb(id_wb), .id_m(id_m), .id_ex(id_ex), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
        .ex_ex(ex_ex), .ex_m(ex_m), .ex_wb(ex_wb),
        .mem_m(mem_m), .mem_wb(mem_wb), .wb_wb(wb_wb),
        .ex_dest(ex_dest), .mem_dest(mem_dest), .wb_dest(wb_dest),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .flush_ifid(flush_ifid),
        .branch_taken(branch_taken), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd);
        ctrl_t c;
        c = decode(op);
        id_wb = c.wb; id_m = c.m; id_ex = c.ex;
        id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rd = rd;
        #1;
    endtask

    task automatic nop();
        id_wb = '0; id_m = '0; id_ex = '0; id_valid = 1'b0;
        id_rs = '0; id_rt = '0; id_rd = '0;
        #1;
    endtask

    task automatic apply_reset();
        nop();
        ex_zero = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string name);
        logic [69:0] all_out;
        all_out = {ex_ex, ex_m, ex_wb, mem_m, mem_wb, wb_wb, ex_dest, mem_dest, wb_dest,
                   fwd_a, fwd_b, stall, flush_ifid, branch_taken, retired};
        vectors++;
        if (all_out !== '0) begin
            miscompares++;
            $display("FAIL %s: outputs=%h want 0", name, all_out);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            id_wb = 2'($urandom); id_m = 3'($urandom); id_ex = 4'($urandom);
            id_valid = 1'b1; id_rs = 5'($urandom); id_rt = 5'($urandom);
            id_rd = 5'($urandom); ex_zero = 1'($urandom);
            tick();
            check_all_zero("reset_hold");
        end
        ex_zero = 1'b0;
        rst_n = 1'b1;
        drive(OP_RTYPE, 5'd1, 5'd2, 5'd3);
        tick();
        vectors++;
        if ({ex_ex, ex_dest} !== {4'b1010, 5'd3}) begin
            miscompares++;
            $display("FAIL reset_first_capture: ex_ex=%b ex_dest=%0d want 1010/3", ex_ex, ex_dest);
        end
    endtask

    task automatic test_rtype();
        apply_reset();
        drive(OP_RTYPE, 5'd1, 5'd2, 5'd3);
        tick();
        vectors++;
        if ({ex_ex, ex_m, ex_wb, ex_dest} !== {4'b1010, 3'b000, 2'b10, 5'd3}) begin
            miscompares++;
            $display("FAIL rtype_edge1: ex=%b m=%b wb=%b dest=%0d", ex_ex, ex_m, ex_wb, ex_dest);
        end
        nop();
        tick();
        vectors++;
        if ({mem_wb, mem_dest, ex_ex} !== {2'b10, 5'd3, 4'b0000}) begin
            miscompares++;
            $display("FAIL rtype_edge2: mem_wb=%b mem_dest=%0d ex_ex=%b", mem_wb, mem_dest, ex_ex);
        end
        tick();
        vectors++;
        if ({wb_wb, wb_dest, retired} !== {2'b10, 5'd3, 32'd0}) begin
            miscompares++;
            $display("FAIL rtype_edge3: wb_wb=%b wb_dest=%0d retired=%0d", wb_wb, wb_dest, retired);
        end
        tick();
        vectors++;
        if (retired !== 32'd1) begin
            miscompares++;
            $display("FAIL rtype_retired: got %0d want 1", retired);
        end
        tick();
        vectors++;
        if (retired !== 32'd1) begin
            miscompares++;
            $display("FAIL rtype_retired_hold: got %0d want 1", retired);
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        drive(OP_LW, 5'd1, 5'd2, 5'd0);
        tick();
        drive(OP_RTYPE, 5'd2, 5'd4, 5'd6);
        vectors++;
        if (stall !== 1'b1) begin
            miscompares++;
            $display("FAIL lu_stall: got %b want 1", stall);
        end
        tick();
        vectors++;
        if ({ex_ex, ex_m, ex_wb, mem_m, stall} !== {4'b0, 3'b0, 2'b0, 3'b010, 1'b0}) begin
            miscompares++;
            $display("FAIL lu_bubble: ex=%b m=%b wb=%b mem_m=%b stall=%b",
                     ex_ex, ex_m, ex_wb, mem_m, stall);
        end
        tick();
        vectors++;
        if ({ex_ex, ex_dest, fwd_a, fwd_b} !== {4'b1010, 5'd6, 2'b01, 2'b00}) begin
            miscompares++;
            $display("FAIL lu_fwd: ex=%b dest=%0d fwd_a=%b fwd_b=%b", ex_ex, ex_dest, fwd_a, fwd_b);
        end
        nop();
        repeat (3) tick();
        vectors++;
        if (retired !== 32'd2) begin
            miscompares++;
            $display("FAIL lu_retired: got %0d want 2", retired);
        end
    endtask

    task automatic test_forwarding();
        apply_reset();
        drive(OP_RTYPE, 5'd1, 5'd2, 5'd5);
        tick();
        drive(OP_RTYPE, 5'd5, 5'd5, 5'd7);
        tick();
        vectors++;
        if ({fwd_a, fwd_b} !== {2'b10, 2'b10}) begin
            miscompares++;
            $display("FAIL fwd_mem: fwd_a=%b fwd_b=%b want 10/10", fwd_a, fwd_b);
        end

        apply_reset();
        drive(OP_RTYPE, 5'd1, 5'd2, 5'd5);
        tick();
        nop();
        tick();
        drive(OP_RTYPE, 5'd5, 5'd5, 5'd7);
        tick();
        vectors++;
        if ({fwd_a, fwd_b} !== {2'b01, 2'b01}) begin
            miscompares++;
            $display("FAIL fwd_wb: fwd_a=%b fwd_b=%b want 01/01", fwd_a, fwd_b);
        end

        apply_reset();
        drive(OP_RTYPE, 5'd1, 5'd2, 5'd0);
        tick();
        drive(OP_RTYPE, 5'd0, 5'd0, 5'd7);
        tick();
        vectors++;
        if ({fwd_a, fwd_b} !== {2'b00, 2'b00}) begin
            miscompares++;
            $display("FAIL fwd_r0: fwd_a=%b fwd_b=%b want 00/00", fwd_a, fwd_b);
        end

        apply_reset();
        drive(OP_RTYPE, 5'd1, 5'd2, 5'd5);
        tick();
        drive(OP_RTYPE, 5'd3, 5'd4, 5'd5);
        tick();
        drive(OP_RTYPE, 5'd5, 5'd9, 5'd7);
        tick();
        vectors++;
        if ({fwd_a, fwd_b} !== {2'b10, 2'b00}) begin
            miscompares++;
            $display("FAIL fwd_priority: fwd_a=%b fwd_b=%b want 10/00", fwd_a, fwd_b);
        end
        nop();
    endtask

    task automatic test_branch();
        apply_reset();
        drive(OP_BEQ, 5'd1, 5'd2, 5'd0);
        tick();
        ex_zero = 1'b1;
        drive(OP_RTYPE, 5'd1, 5'd2, 5'd8);
        vectors++;
        if (branch_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL br_early: branch_taken=%b want 0", branch_taken);
        end
        tick();
        ex_zero = 1'b0;
        drive(OP_RTYPE, 5'd1, 5'd2, 5'd9);
        vectors++;
        if ({branch_taken, flush_ifid, mem_m} !== {1'b1, 1'b1, 3'b100}) begin
            miscompares++;
            $display("FAIL br_taken: bt=%b flush=%b mem_m=%b want 1/1/100",
                     branch_taken, flush_ifid, mem_m);
        end
        tick();
        nop();
        vectors++;
        if ({branch_taken, mem_m, mem_wb, ex_ex, ex_wb} !== {1'b0, 3'b0, 2'b0, 4'b0, 2'b0}) begin
            miscompares++;
            $display("FAIL br_squash: bt=%b mem_m=%b mem_wb=%b ex_ex=%b ex_wb=%b",
                     branch_taken, mem_m, mem_wb, ex_ex, ex_wb);
        end
        repeat (3) tick();
        vectors++;
        if ({retired, wb_wb} !== {32'd1, 2'b00}) begin
            miscompares++;
            $display("FAIL br_retired: retired=%0d wb_wb=%b want 1/00", retired, wb_wb);
        end

        apply_reset();
        drive(OP_BEQ, 5'd1, 5'd2, 5'd0);
        tick();
        ex_zero = 1'b0;
        drive(OP_RTYPE, 5'd1, 5'd2, 5'd8);
        tick();
        nop();
        vectors++;
        if ({branch_taken, flush_ifid} !== 2'b00) begin
            miscompares++;
            $display("FAIL br_not_taken: bt=%b flush=%b want 0/0", branch_taken, flush_ifid);
        end
        tick();
        vectors++;
        if ({mem_wb, mem_dest} !== {2'b10, 5'd8}) begin
            miscompares++;
            $display("FAIL br_fallthru: mem_wb=%b mem_dest=%0d want 10/8", mem_wb, mem_dest);
        end
    endtask

    task automatic test_flush_vs_stall();
        apply_reset();
        drive(OP_BEQ, 5'd1, 5'd2, 5'd0);
        tick();
        ex_zero = 1'b1;
        drive(OP_LW, 5'd1, 5'd2, 5'd0);
        tick();
        ex_zero = 1'b0;
        drive(OP_RTYPE, 5'd2, 5'd3, 5'd4);
        vectors++;
        if ({ex_m, branch_taken, stall} !== {3'b010, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL flush_over_stall: ex_m=%b bt=%b stall=%b want 010/1/0",
                     ex_m, branch_taken, stall);
        end
        tick();
        nop();
        vectors++;
        if ({mem_m, ex_ex} !== {3'b000, 4'b0000}) begin
            miscompares++;
            $display("FAIL flush_load_squashed: mem_m=%b ex_ex=%b want 000/0000", mem_m, ex_ex);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive(OP_RTYPE, 5'd1, 5'd2, 5'd3);
        tick();
        drive(OP_RTYPE, 5'd3, 5'd3, 5'd4);
        tick();
        drive(OP_RTYPE, 5'd4, 5'd4, 5'd5);
        tick();
        drive(OP_LW, 5'd5, 5'd6, 5'd0);
        tick();
        vectors++;
        if (retired !== 32'd1) begin
            miscompares++;
            $display("FAIL mid_prefill: retired=%0d want 1", retired);
        end
        nop();
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset_async");
        rst_n = 1'b1;
        drive(OP_RTYPE, 5'd1, 5'd2, 5'd6);
        tick();
        vectors++;
        if ({ex_ex, ex_dest, mem_wb, wb_wb, retired} !== {4'b1010, 5'd6, 2'b0, 2'b0, 32'd0}) begin
            miscompares++;
            $display("FAIL mid_restart: ex=%b dest=%0d mem_wb=%b wb_wb=%b retired=%0d",
                     ex_ex, ex_dest, mem_wb, wb_wb, retired);
        end
        nop();
    endtask

    initial begin
        rst_n = 1'b0;
        ex_zero = 1'b0;
        id_wb = '0; id_m = '0; id_ex = '0; id_valid = 1'b0;
        id_rs = '0; id_rt = '0; id_rd = '0;
        test_reset();
        test_rtype();
        test_load_use();
        test_forwarding();
        test_branch();
        test_flush_vs_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
